// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO and its write-side helpers.
// Holds the FIFO core defaults, the lane pad value and the lane index width helper.
package fifo_pkg;

  localparam int   FIFO_DSIZE = 8;
  localparam int   FIFO_ASIZE = 4;
  localparam logic PAD_LANE   = '0;

  function automatic int lane_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_packer.sv
// Write-side packer in front of the async FIFO: gathers IN_W beats into DSIZE words,
// closes partial words on s_last/flush with zero padding, and never writes while wfull.
module fifo_wr_packer
  import fifo_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int RATIO = 4,
  parameter int DSIZE = 32,
  parameter int CNT_W = 16
) (
  input  logic             wclk,
  input  logic             rrst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  input  logic             flush,
  input  logic             wfull,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int              IDX_W    = lane_idx_w(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  generate
    if (DSIZE != IN_W * RATIO) begin : g_bad_dsize
      $error("fifo_wr_packer: DSIZE (%0d) must equal IN_W*RATIO (%0d)", DSIZE, IN_W * RATIO);
    end
    if (RATIO < 2) begin : g_bad_ratio
      $error("fifo_wr_packer: RATIO (%0d) must be at least 2", RATIO);
    end
    if (FIFO_DSIZE <= 0 || FIFO_ASIZE <= 0) begin : g_bad_pkg
      $error("fifo_wr_packer: FIFO core defaults must be positive");
    end
  endgenerate

  logic [DSIZE-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DSIZE-1:0] hold_data_q, hold_data_d;
  logic             hold_valid_q, hold_valid_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic             hold_free;
  logic             accept;
  logic             flush_req;
  logic             beat_close;
  logic             flush_close;
  logic             close;
  logic             drain;
  logic [DSIZE-1:0] merged;

  // A flush accompanied by the first beat of a word still closes, carrying that beat.
  always_comb begin
    hold_free   = !hold_valid_q || !wfull;
    drain       = hold_valid_q && !wfull;
    accept      = s_valid && hold_free;
    flush_req   = flush_pend_q || flush;
    beat_close  = accept && ((idx_q == LAST_IDX) || s_last);
    flush_close = flush_req && hold_free && ((idx_q != '0) || accept);
    close       = beat_close || flush_close;
  end

  // Lanes below idx come from acc, the incoming beat takes lane idx, the rest are padded.
  always_comb begin
    merged = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (accept && (i == int'(idx_q))) begin
        merged[i*IN_W +: IN_W] = s_data;
      end else if (i < int'(idx_q)) begin
        merged[i*IN_W +: IN_W] = acc_q[i*IN_W +: IN_W];
      end else begin
        merged[i*IN_W +: IN_W] = {IN_W{PAD_LANE}};
      end
    end
  end

  always_comb begin
    acc_d        = acc_q;
    idx_d        = idx_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    flush_pend_d = flush_req && !close && (idx_q != '0);
    word_cnt_d   = word_cnt_q + CNT_W'(drain);

    if (drain) begin
      hold_valid_d = 1'b0;
    end

    if (close) begin
      hold_data_d  = merged;
      hold_valid_d = 1'b1;
      acc_d        = '0;
      idx_d        = '0;
    end else if (accept) begin
      acc_d = merged;
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge wclk or negedge rrst_n) begin
    if (!rrst_n) begin
      acc_q        <= '0;
      idx_q        <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      flush_pend_q <= flush_pend_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign winc     = drain;
  assign s_ready  = hold_free;
  assign wdata    = hold_data_q;
  assign word_cnt = word_cnt_q;

endmodule
